// File: rtl/stream_out_port.sv
// Read-side video port: drains a FWFT FIFO into an AXI4-Stream video master.
// It marks frame start (tuser) and line end (tlast), and gates frames and lines for the DMA read engine.
module stream_out_port #(
  parameter int    DSIZE      = 24,
  parameter string MODE       = "ONCE",
  parameter string FRAME_SYNC = "OFF"
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             aclken,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic             fsync,
  input  logic             line_ready,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] axi_tdata,
  output logic             axi_tvalid,
  input  logic             axi_tready,
  output logic             axi_tuser,
  output logic             axi_tlast,
  output logic             frame_start,
  output logic             frame_done
);

  // state     | meaning
  // IDLE      | waiting for frame go (fsync when synced) and non-zero geometry
  // LINE_WAIT | between lines; in LINE mode waits for line_ready
  // LINE_RUN  | popping the FIFO into the output register
  // DRAIN     | last beat loaded, waiting for the sink to accept it
  typedef enum logic [1:0] {IDLE, LINE_WAIT, LINE_RUN, DRAIN} state_t;

  localparam bit LINE_MODE = (MODE == "LINE");
  localparam bit SYNC_ON   = (FRAME_SYNC == "ON");

  state_t      state;
  logic [15:0] hcnt;
  logic [15:0] vcnt;
  logic [15:0] hact_l;
  logic [15:0] vact_l;
  logic        start_q;
  logic        done_q;
  logic        load;
  logic        accept;
  logic        last_pix;
  logic        last_line;
  logic        sync_ok;

  assign accept    = axi_tvalid && axi_tready;
  assign load      = aclken && (state == LINE_RUN) && !fifo_empty && (!axi_tvalid || axi_tready);
  assign last_pix  = (hcnt == hact_l - 16'd1);
  assign last_line = (vcnt == vact_l - 16'd1);
  // An fsync coinciding with the frame_done pulse is dropped; the next one is needed.
  assign sync_ok   = !SYNC_ON || (fsync && !done_q);

  assign fifo_rd_en  = load;
  assign frame_start = start_q && aclken;
  assign frame_done  = done_q && aclken;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      hcnt       <= '0;
      vcnt       <= '0;
      hact_l     <= '0;
      vact_l     <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      axi_tdata  <= '0;
      axi_tvalid <= 1'b0;
      axi_tuser  <= 1'b0;
      axi_tlast  <= 1'b0;
    end else if (aclken) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;

      if (load) begin
        axi_tdata  <= fifo_rd_data;
        axi_tvalid <= 1'b1;
        axi_tuser  <= (hcnt == 16'd0) && (vcnt == 16'd0);
        axi_tlast  <= last_pix;
        if (last_pix) begin
          hcnt <= '0;
          vcnt <= vcnt + 16'd1;
        end else begin
          hcnt <= hcnt + 16'd1;
        end
      end else if (accept) begin
        axi_tvalid <= 1'b0;
        axi_tuser  <= 1'b0;
        axi_tlast  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sync_ok && (hactive != 16'd0) && (vactive != 16'd0)) begin
            hact_l  <= hactive;
            vact_l  <= vactive;
            start_q <= 1'b1;
            state   <= LINE_WAIT;
          end
        end
        LINE_WAIT: begin
          if (!LINE_MODE || line_ready) state <= LINE_RUN;
        end
        LINE_RUN: begin
          if (load && last_pix) state <= last_line ? DRAIN : LINE_WAIT;
        end
        DRAIN: begin
          if (accept) begin
            done_q <= 1'b1;
            hcnt   <= '0;
            vcnt   <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_out_port.sv
// Bench for stream_out_port: a free-running ONCE/OFF port checked against a frame-level scoreboard,
// plus a LINE/ON port exercised with directed fsync and line_ready sequences.
module tb_stream_out_port;

  localparam int DW = 24;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          aclken;
  logic [15:0]   hactive, vactive;
  logic          fsync, line_ready, fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [DW-1:0] axi_tdata;
  logic          axi_tvalid, axi_tready, axi_tuser, axi_tlast;
  logic          frame_start, frame_done;

  logic [15:0]   hactive2, vactive2;
  logic          fsync2, line_ready2, fifo_empty2;
  logic [DW-1:0] fifo_rd_data2;
  logic          fifo_rd_en2;
  logic [DW-1:0] axi_tdata2;
  logic          axi_tvalid2, axi_tready2, axi_tuser2, axi_tlast2;
  logic          frame_start2, frame_done2;

  always #5 aclk = ~aclk;

  stream_out_port #(.DSIZE(DW), .MODE("ONCE"), .FRAME_SYNC("OFF")) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .vactive(vactive), .hactive(hactive), .fsync(fsync), .line_ready(line_ready),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tready(axi_tready),
    .axi_tuser(axi_tuser), .axi_tlast(axi_tlast),
    .frame_start(frame_start), .frame_done(frame_done)
  );

  stream_out_port #(.DSIZE(DW), .MODE("LINE"), .FRAME_SYNC("ON")) dut2 (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .vactive(vactive2), .hactive(hactive2), .fsync(fsync2), .line_ready(line_ready2),
    .fifo_empty(fifo_empty2), .fifo_rd_data(fifo_rd_data2), .fifo_rd_en(fifo_rd_en2),
    .axi_tdata(axi_tdata2), .axi_tvalid(axi_tvalid2), .axi_tready(axi_tready2),
    .axi_tuser(axi_tuser2), .axi_tlast(axi_tlast2),
    .frame_start(frame_start2), .frame_done(frame_done2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents, words in flight to the sink, and frame geometry/progress.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] popped[$];
  int  beat, cur_h, cur_v, nframes;
  bit  in_idle, start_pend, done_pend;

  logic [DW-1:0] d2_next;
  int  b2;
  logic s2_valid, s2_user, s2_last, s2_start, s2_done, s2_rd;
  logic [DW-1:0] s2_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [DW-1:0] w;
    chk("tvalid_inflight", 32'(axi_tvalid), 32'(popped.size() != 0));
    if (!aclken) begin
      chk("en_rd_en", 32'(fifo_rd_en), 0);
      chk("en_start", 32'(frame_start), 0);
      chk("en_done", 32'(frame_done), 0);
      return;
    end
    chk("frame_start", 32'(frame_start), 32'(start_pend));
    start_pend = 0;
    chk("frame_done", 32'(frame_done), 32'(done_pend));
    if (done_pend) begin
      in_idle = 1;
      nframes++;
    end
    done_pend = 0;
    if (in_idle && hactive != 0 && vactive != 0) begin
      in_idle = 0;
      start_pend = 1;
      cur_h = int'(hactive);
      cur_v = int'(vactive);
      beat = 0;
    end
    if (fifo_empty) chk("rd_en_empty", 32'(fifo_rd_en), 0);
    if (axi_tvalid && !axi_tready) chk("rd_en_stall", 32'(fifo_rd_en), 0);
    if (in_idle && !start_pend) chk("rd_en_idle", 32'(fifo_rd_en), 0);
    if (axi_tvalid && axi_tready) begin
      w = (popped.size() != 0) ? popped.pop_front() : '0;
      chk("tdata", 32'(axi_tdata), 32'(w));
      chk("tuser", 32'(axi_tuser), 32'(beat == 0));
      chk("tlast", 32'(axi_tlast), 32'((beat % cur_h) == cur_h - 1));
      beat++;
      if (beat == cur_h * cur_v) begin
        done_pend = 1;
        beat = 0;
      end
    end
    if (fifo_rd_en && fifo_q.size() != 0) popped.push_back(fifo_q.pop_front());
  endtask

  task automatic cycle();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_rd_data  = fifo_empty ? '0 : fifo_q[0];
    fifo_rd_data2 = d2_next;
    @(negedge aclk);
    #1;
    if (aresetn) model_step();
    else chk("rst_rd_en", 32'(fifo_rd_en), 0);
    s2_valid = axi_tvalid2; s2_user = axi_tuser2; s2_last = axi_tlast2; s2_data = axi_tdata2;
    s2_start = frame_start2; s2_done = frame_done2; s2_rd = fifo_rd_en2;
    if (fifo_rd_en2) d2_next++;
    @(posedge aclk);
    #1;
  endtask

  task automatic push_n(input int n, input bit counting, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(counting ? DW'(base + i) : DW'($urandom));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", 32'(axi_tvalid), 0);
    chk("rst_tdata", 32'(axi_tdata), 0);
    chk("rst_tuser", 32'(axi_tuser), 0);
    chk("rst_tlast", 32'(axi_tlast), 0);
    chk("rst_start", 32'(frame_start), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_tvalid2", 32'(axi_tvalid2), 0);
    fifo_q.delete();
    popped.delete();
    beat = 0; in_idle = 1; start_pend = 0; done_pend = 0;
    d2_next = '0; b2 = 0;
    push_n(3, 1, 16'h100);
    repeat (3) cycle();
    aresetn = 1'b1;
  endtask

  task automatic run2(input int n, input bit fs_on_done, output int nb, output int ns, output int nd);
    nb = 0; ns = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      fsync2 = fs_on_done && frame_done2;
      cycle();
      if (s2_valid) begin
        chk("l_tdata", 32'(s2_data), 32'(b2));
        chk("l_tuser", 32'(s2_user), 32'(b2 == 0));
        chk("l_tlast", 32'(s2_last), 32'((b2 % 3) == 2));
        b2++;
        nb++;
      end
      ns += int'(s2_start);
      nd += int'(s2_done);
    end
    fsync2 = 1'b0;
  endtask

  initial begin
    int nb, ns, nd, f0;
    aresetn = 1'b0; aclken = 1'b1;
    hactive = 16'd4; vactive = 16'd2; fsync = 1'b0; line_ready = 1'b0;
    axi_tready = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0;
    hactive2 = 16'd3; vactive2 = 16'd2; fsync2 = 1'b0; line_ready2 = 1'b0;
    fifo_empty2 = 1'b0; axi_tready2 = 1'b1; fifo_rd_data2 = '0;
    beat = 0; cur_h = 1; cur_v = 1; nframes = 0; d2_next = '0; b2 = 0;
    in_idle = 1; start_pend = 0; done_pend = 0;
    #2;
    do_reset();
    fifo_q.delete();

    // Straight 4x2 frame of 0..7, sink always ready.
    push_n(8, 1, 0);
    repeat (20) cycle();
    chk("frames_after_first", 32'(nframes), 1);

    // Backpressure mid-line.
    push_n(8, 1, 8);
    repeat (3) cycle();
    axi_tready = 1'b0;
    repeat (3) cycle();
    axi_tready = 1'b1;
    repeat (15) cycle();

    // Underrun after five words, refilled later.
    push_n(5, 1, 16);
    repeat (12) cycle();
    push_n(3, 1, 21);
    repeat (10) cycle();

    // Clock enable low for four cycles with the sink ready.
    push_n(6, 1, 32);
    repeat (2) cycle();
    aclken = 1'b0;
    repeat (4) cycle();
    aclken = 1'b1;
    repeat (12) cycle();

    // Random traffic; geometry inputs wander every cycle and must only matter at frame entry.
    for (int i = 0; i < 1500; i++) begin
      axi_tready = ($urandom_range(0, 3) != 0);
      aclken     = ($urandom_range(0, 7) != 0);
      hactive    = 16'($urandom_range(1, 4));
      vactive    = 16'($urandom_range(1, 3));
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) push_n(1, 0, 0);
      cycle();
    end
    aclken = 1'b1;
    axi_tready = 1'b1;
    chk("frames_progressed", 32'(nframes > 20), 1);

    // Reset in the middle of a line, then zero geometry keeps the port idle.
    hactive = 16'd4; vactive = 16'd2;
    push_n(6, 0, 0);
    repeat (4) cycle();
    hactive = 16'd0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("zero_geom_rd_en", 32'(fifo_rd_en), 0);
    end

    // Frame-synced, line-gated port.
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("fs_idle_valid", 32'(s2_valid), 0);
      chk("fs_idle_rd", 32'(s2_rd), 0);
      chk("fs_idle_start", 32'(s2_start), 0);
    end
    fsync2 = 1'b1;
    cycle();
    fsync2 = 1'b0;
    chk("fs_start_early", 32'(s2_start), 0);
    cycle();
    chk("fs_start", 32'(s2_start), 1);
    for (int i = 0; i < 8; i++) begin
      fsync2 = (i == 3);
      cycle();
      chk("lw_valid", 32'(s2_valid), 0);
      chk("lw_rd", 32'(s2_rd), 0);
      chk("lw_start", 32'(s2_start), 0);
    end
    fsync2 = 1'b0;
    line_ready2 = 1'b1;
    cycle();
    line_ready2 = 1'b0;
    run2(8, 0, nb, ns, nd);
    chk("line0_beats", 32'(nb), 3);
    chk("line0_done", 32'(nd), 0);
    run2(6, 0, nb, ns, nd);
    chk("gap_beats", 32'(nb), 0);
    line_ready2 = 1'b1;
    cycle();
    line_ready2 = 1'b0;
    run2(10, 1, nb, ns, nd);
    chk("line1_beats", 32'(nb), 3);
    chk("frame2_done", 32'(nd), 1);
    chk("fs_mid_ignored", 32'(ns), 0);
    run2(6, 0, nb, ns, nd);
    chk("fs_on_done_lost", 32'(ns), 0);
    fsync2 = 1'b1;
    cycle();
    fsync2 = 1'b0;
    chk("fs2_start_early", 32'(s2_start), 0);
    cycle();
    chk("fs2_start", 32'(s2_start), 1);

    // Main port resumes with hactive=1: every beat carries tlast.
    f0 = nframes;
    hactive = 16'd1; vactive = 16'd3;
    push_n(3, 0, 0);
    repeat (12) cycle();
    chk("h1_frame", 32'(nframes - f0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_out_port.md
Name: stream_out_port

Overview:
Read-side counterpart of the VDMA input port. It pulls pixels from the read-channel FIFO, which is first-word-fall-through, and emits them as an AXI4-Stream video master. It raises tuser on the first pixel of each frame and tlast on the last pixel of each line, with line and frame geometry taken from hactive/vactive. It sits between the VDMA read FIFO and the downstream video sink and supplies frame pacing (fsync gating, per-line gating) back to the DMA read engine.

Parameters:
DSIZE, 24, pixel/tdata width in bits
MODE, "ONCE", "ONCE": stream the whole frame continuously; "LINE": wait for line_ready before starting each line
FRAME_SYNC, "OFF", "OFF": start the next frame immediately; "ON": wait for an fsync pulse before each frame

Ports:
aclk  input  1  stream clock; the only clock in the block
aresetn  input  1  reset, asynchronous, active-low
aclken  input  1  clock enable; when low, all state, counters and outputs freeze
vactive  input  16  lines per frame; sampled at frame start
hactive  input  16  pixels per line; sampled at frame start
fsync  input  1  frame start pulse; used only when FRAME_SYNC="ON"
line_ready  input  1  a full line is available in the FIFO; used only when MODE="LINE"
fifo_empty  input  1  read FIFO empty
fifo_rd_data  input  DSIZE  FWFT head word; valid whenever fifo_empty=0
fifo_rd_en  output  1  pop the FIFO head this cycle
axi_tdata  output  DSIZE  pixel
axi_tvalid  output  1  beat valid
axi_tready  input  1  sink ready
axi_tuser  output  1  start of frame (first beat of frame)
axi_tlast  output  1  end of line (last beat of line)
frame_start  output  1  one-cycle pulse when a frame is entered
frame_done  output  1  one-cycle pulse when the last beat of a frame is accepted

Behaviour:
- Reset values: axi_tvalid/tuser/tlast=0, axi_tdata=0, fifo_rd_en=0, frame_start=0, frame_done=0, state=IDLE, hcnt=vcnt=0.
- All behaviour below assumes aclken=1. With aclken=0: fifo_rd_en=0, pulses=0, every register holds.
- Registered output stage, one entry.
  - load = (state==LINE_RUN) && !fifo_empty && (!axi_tvalid || axi_tready).
  - fifo_rd_en = load (combinational).
  - The loaded word appears on axi_tdata, with tvalid=1, on the next cycle; latency is 1 cycle from FIFO head to tdata.
- AXIS rules:
  - tdata/tuser/tlast are stable while tvalid=1 and tready=0.
  - A beat transfers on tvalid&&tready; tvalid drops after the transfer if no new load occurs.
  - FIFO underrun only deasserts tvalid. No error and no counter advance.
- Counters are 16-bit and advance on load.
  - Loaded beat flags: tuser = (hcnt==0 && vcnt==0); tlast = (hcnt==hact_l-1).
  - hcnt wraps to 0 after hact_l-1; vcnt increments on each wrap.
- hact_l/vact_l are latched when leaving IDLE. Input changes mid-frame have no effect.
- States:
  - IDLE: if FRAME_SYNC="OFF", or fsync=1, and hactive!=0 and vactive!=0, then latch geometry, pulse frame_start, and go to LINE_WAIT. Zero geometry keeps the block in IDLE.
  - LINE_WAIT: with MODE="ONCE", go to LINE_RUN next cycle. With MODE="LINE", go to LINE_RUN when line_ready=1.
  - LINE_RUN: loads beats. When the load carries tlast: if it is the last line (vcnt==vact_l-1), go to DRAIN; else go to LINE_WAIT.
  - DRAIN: when the final beat is accepted, pulse frame_done, clear counters, and go to IDLE.
- In LINE_WAIT, the output stage may still be presenting the previous tlast beat; it completes normally.
- fsync outside IDLE is ignored. A frame is never truncated or restarted.
- FRAME_SYNC="ON": an fsync arriving in the same cycle frame_done fires is lost; the next fsync is required. IDLE is entered only the cycle after frame_done.
- hactive=1 is valid: every beat carries tlast; the first beat carries both tuser and tlast.
- Reset mid-frame: all outputs clear immediately (asynchronous). The FIFO is not popped during reset; flushing the FIFO is the DMA's responsibility.

Test Plan:
- Frame, no stalls: ONCE/OFF, hactive=4, vactive=2, FIFO holds 0..7, tready=1. Expect 8 beats with tdata 0..7. tuser on beat 0 only. tlast on beats 3 and 7. frame_done 1 cycle after beat 7. frame_start again the following cycle.
- Backpressure: same setup, tready low for 3 cycles while beat 2 is valid. Expect tdata=2/tuser=0/tlast=0 held stable, fifo_rd_en=0 during the stall, then a correct sequence.
- Underrun: FIFO empty after 5 words, refilled 10 cycles later. Expect tvalid=0 during the gap. Beat 5 continues with hcnt/vcnt intact (tlast on beat 7).
- Frame sync: FRAME_SYNC="ON". Expect no activity until fsync. An fsync during the frame is ignored. frame_start occurs exactly 1 cycle after a post-frame_done fsync.
- Line gating: MODE="LINE", hactive=3, line_ready pulsed at cycles 10 and 30. Expect line 0 beats only after cycle 10 and line 1 beats only after cycle 30.
- Reset/enable: aresetn low mid-line gives all outputs 0 immediately. After release, the first beat carries tuser. aclken=0 for 4 cycles freezes tvalid/tdata/counters.
